mul_iter_ctrl: RTL and testbench
================================

// Module: mul_iter_ctrl
// PURPOSE
//  Multi-cycle controller for MULT/MULTU/MADD/MADDU/MSUB/MSUBU on a single booth2 radix-4 partial-product generator.
//  Takes one 32x32 request from the EX stage and walks the 17 Booth digits of the 33-bit sign/zero-extended multiplier, one per cycle.
//  Accumulates partial products into a 64-bit HI/LO result, optionally seeded with the current HI/LO value.
//  Sits between EX stall logic and the HI/LO register file.
// PARAMETERS
//  ITER      17   Booth digits per operation (33-bit multiplier / 2, rounded up)
//  CNT_W     5    iteration counter width
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  resetn     in   1   asynchronous, active-low reset
//  start      in   1   request strobe; accepted only in IDLE
//  signed_op  in   1   1: operands signed (MULT/MADD/MSUB); 0: unsigned
//  is_macc    in   1   1: accumulator seeded from hilo_in; 0: seeded with 0
//  is_msub    in   1   1: subtract product (MSUB/MSUBU); passed to booth2
//  opa        in   32  multiplicand (rs)
//  opb        in   32  multiplier (rt)
//  hilo_in    in   64  {HI,LO} sampled at accept when is_macc=1
//  cancel     in   1   flush from exception/branch; aborts operation
//  busy       out  1   1 from the cycle after accept until the end of DONE; drives EX stall
//  done       out  1   one-cycle pulse, result valid
//  result     out  64  {HI,LO}; held until next accept
// BEHAVIOUR
//  Reset (async): state=IDLE, busy=0, done=0, result=0, cnt=0, acc=0.
//  States: IDLE -> CALC on (start & !cancel); CALC -> DONE when cnt==ITER-1; DONE -> IDLE always.
//  cancel in CALC or DONE -> IDLE next edge. done is not asserted. result keeps its previous value.
//  At accept, latch the following:
//    x   = {signed_op & opa[31], opa}      (33 b)
//    ysh = {signed_op & opb[31], signed_op & opb[31], opb, 1'b0}  (35 b)
//    acc = is_macc ? hilo_in : 64'b0
//    cnt = 0
//    is_msub
//  CALC cycle k (k = 0..16):
//    pp  = booth2(x, ysh[2:0], is_msub)
//    acc <= acc + (pp << 2k), computed mod 2^64; carries above bit 63 are dropped
//    ysh <= ysh >> 2; cnt <= cnt+1
//  DONE: result <= acc is registered on the CALC->DONE edge and is visible during DONE; done=1 for exactly one cycle.
//  Latency: accept at edge 0; done high in the cycle after edge 17, i.e. 18 cycles from start to done.
//  busy = (state != IDLE). The start strobe itself is not registered as busy; EX must stall combinationally on start.
//  start while busy: ignored and not queued.
//  start & cancel in the same cycle in IDLE: cancel wins and the request is dropped.
//  Back-to-back: start in the DONE cycle is ignored. Earliest next accept is the first IDLE cycle.
//  Unsigned operands must give an exact 64-bit product, e.g. 0xFFFFFFFF^2.
//  Signed operands give the two's-complement product mod 2^64.
//  MSUB result = hilo_in - a*b mod 2^64, produced by booth2 negated digits, not by a final negate.
// STRUCTURE
//  Shared header mul_defines.vh:
//    state encodings IDLE=2'd0, CALC=2'd1, DONE=2'd2
//    `MUL_ITER 17
//  One sub-module: booth2 (existing partial-product generator), one instance.
//  Everything else stays in this file: FSM, counter, shift register, 64-bit adder, variable shifter on pp.
// TESTING
//  1 MULTU 3*5, is_macc=0 -> done 18 cycles after start, result=0x0000_0000_0000_000F.
//  2 MULT 0xFFFFFFFF*0xFFFFFFFF -> result=0x0000_0000_0000_0001.
//    MULTU same operands -> result=0xFFFF_FFFE_0000_0001.
//  3 MADD hilo_in=10, 2*3 -> result=16.
//    MSUB hilo_in=10, 4*3 -> result=0xFFFF_FFFF_FFFF_FFFE.
//    MSUBU hilo_in=0, 0x80000000*2 -> result=0xFFFF_FFFF_0000_0000.
//  4 cancel asserted 5 cycles after accept -> busy=0 next cycle, no done pulse, result unchanged.
//    A new start is then accepted normally.
//  5 start held high throughout an op with different operands -> only the first is computed.
//    done pulses once. Next accept happens only after IDLE is reached.
//  6 resetn pulled low mid-CALC (async, between edges) -> busy/done/result zero immediately.
//    After release, MULTU 7*9=63 completes correctly.

Source files
------------

// File: rtl/mul_iter_ctrl_pkg.sv
// mul_iter_ctrl_pkg
//   Shared constants and types for the iterative Booth radix-4 multiply
//   controller: iteration count, counter width and FSM state encoding.
package mul_iter_ctrl_pkg;

    localparam int ITER  = 17;   // Booth digits of a 33-bit multiplier
    localparam int CNT_W = 5;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mul_iter_ctrl_if.sv
// mul_iter_ctrl_if
//   Request/response bundle between the EX stage and the multiply controller.
//   master : EX side (drives the request, observes busy/done/result)
//   slave  : controller side
//   start/signed_op/is_macc/is_msub/opa/opb/hilo_in/cancel : request
//   busy/done/result                                       : response
interface mul_iter_ctrl_if;
    logic        start;
    logic        signed_op;
    logic        is_macc;
    logic        is_msub;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [63:0] hilo_in;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [63:0] result;

    modport master (
        output start, signed_op, is_macc, is_msub, opa, opb, hilo_in, cancel,
        input  busy, done, result
    );

    modport slave (
        input  start, signed_op, is_macc, is_msub, opa, opb, hilo_in, cancel,
        output busy, done, result
    );
endinterface

// File: rtl/mul_iter_ctrl_booth2.sv
// mul_iter_ctrl_booth2
//   Radix-4 Booth partial-product generator (combinational).
//   x_i   : 33-bit sign/zero-extended multiplicand
//   dig_i : Booth window {y[2k+1], y[2k], y[2k-1]}
//   neg_i : negate the partial product (multiply-subtract)
//   pp_o  : digit * x, sign-extended to 64 bits, negated when neg_i=1
module mul_iter_ctrl_booth2 (
    input  logic [32:0] x_i,
    input  logic [2:0]  dig_i,
    input  logic        neg_i,
    output logic [63:0] pp_o
);

    logic [63:0] x_ext;
    logic [63:0] mag;
    logic        neg_dig;

    assign x_ext = {{31{x_i[32]}}, x_i};

    always_comb begin
        mag     = '0;
        neg_dig = 1'b0;
        case (dig_i)
            3'b001, 3'b010: mag = x_ext;
            3'b011:         mag = x_ext << 1;
            3'b100: begin
                mag     = x_ext << 1;
                neg_dig = 1'b1;
            end
            3'b101, 3'b110: begin
                mag     = x_ext;
                neg_dig = 1'b1;
            end
            default:        mag = '0;
        endcase
        // Negating a zero magnitude still yields zero, so digits 000/111 are safe.
        pp_o = (neg_dig ^ neg_i) ? (~mag + 64'd1) : mag;
    end

endmodule

// File: rtl/mul_iter_ctrl.sv
// mul_iter_ctrl
//   Multi-cycle MULT/MULTU/MADD/MADDU/MSUB/MSUBU controller. Walks one Booth
//   radix-4 digit per cycle and accumulates into a 64-bit {HI,LO} value,
//   optionally seeded from hilo_in.
//   clk    : system clock
//   resetn : asynchronous active-low reset
//   bus    : request/response bundle (slave side)
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start; only state that accepts a request
//   CALC  | one Booth digit accumulated per cycle, cnt = 0..ITER-1
//   DONE  | result valid, done pulses for this single cycle
module mul_iter_ctrl
    import mul_iter_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    mul_iter_ctrl_if.slave   bus
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [32:0]        x_q, x_d;
    logic [34:0]        ysh_q, ysh_d;
    logic [63:0]        acc_q, acc_d;
    logic [63:0]        result_q, result_d;
    logic               msub_q, msub_d;
    logic [63:0]        pp;
    logic [63:0]        pp_sh;
    logic [63:0]        acc_sum;
    logic               a_ext, b_ext;

    mul_iter_ctrl_booth2 u_booth2 (
        .x_i   (x_q),
        .dig_i (ysh_q[2:0]),
        .neg_i (msub_q),
        .pp_o  (pp)
    );

    // Digit k carries weight 4^k; bits shifted past 63 are dropped (mod 2^64).
    assign pp_sh   = pp << {cnt_q, 1'b0};
    assign acc_sum = acc_q + pp_sh;

    assign a_ext = bus.signed_op & bus.opa[31];
    assign b_ext = bus.signed_op & bus.opb[31];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        ysh_d    = ysh_q;
        acc_d    = acc_q;
        result_d = result_q;
        msub_d   = msub_q;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.cancel) begin
                    state_d = CALC;
                    x_d     = {a_ext, bus.opa};
                    ysh_d   = {b_ext, b_ext, bus.opb, 1'b0};
                    acc_d   = bus.is_macc ? bus.hilo_in : 64'd0;
                    cnt_d   = '0;
                    msub_d  = bus.is_msub;
                end
            end
            CALC: begin
                if (bus.cancel) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_sum;
                    ysh_d = ysh_q >> 2;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d  = DONE;
                        result_d = acc_sum;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            x_q      <= '0;
            ysh_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            msub_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            ysh_q    <= ysh_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            msub_q   <= msub_d;
        end
    end

    assign bus.busy   = (state_q != IDLE);
    // A flush arriving in DONE suppresses the pulse.
    assign bus.done   = (state_q == DONE) && !bus.cancel;
    assign bus.result = result_q;

endmodule

// File: tb/tb_mul_iter_ctrl.sv
module tb_mul_iter_ctrl;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [63:0] res_model;

    mul_iter_ctrl_if bus ();

    mul_iter_ctrl dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic on the architectural operands.
    function automatic logic [63:0] ref_result(input bit sgn, input bit macc, input bit msub,
                                               input logic [31:0] a, input logic [31:0] b,
                                               input logic [63:0] hilo);
        longint sa, sb;
        logic [63:0] p;
        sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        p  = 64'(sa * sb);
        return (macc ? hilo : 64'd0) + (msub ? (64'd0 - p) : p);
    endfunction

    // Issues one request and watches 20 cycles after the accept edge.
    // n = number of rising edges since the accept edge at each sample point.
    task automatic do_op(input string tag, input bit sgn, input bit macc, input bit msub,
                         input logic [31:0] a, input logic [31:0] b, input logic [63:0] hilo,
                         input int cancel_at, input bit hold);
        logic [63:0] exp;
        logic [63:0] got;
        int done_at, done_cnt, busy_err;
        bit exp_busy;
        exp = (cancel_at >= 0) ? res_model : ref_result(sgn, macc, msub, a, b, hilo);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.signed_op = sgn;
        bus.is_macc   = macc;
        bus.is_msub   = msub;
        bus.opa       = a;
        bus.opb       = b;
        bus.hilo_in   = hilo;
        bus.cancel    = 1'b0;
        @(negedge clk);
        if (!hold) begin
            bus.start = 1'b0;
        end else begin
            bus.opa     = $urandom;
            bus.opb     = $urandom;
            bus.hilo_in = {$urandom, $urandom};
            bus.is_macc = ~macc;
        end
        done_at  = -1;
        done_cnt = 0;
        busy_err = 0;
        got      = '0;
        for (int n = 0; n < 20; n++) begin
            exp_busy = (cancel_at >= 0) ? (n <= cancel_at) : (n <= 17);
            if (bus.busy !== exp_busy) busy_err++;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = n;
                    got     = bus.result;
                end
            end
            bus.cancel = (n == cancel_at);
            if (hold && n == 18) bus.start = 1'b0;
            @(negedge clk);
        end
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        check({tag, ":busy_trace"}, 64'(busy_err), 64'd0);
        if (cancel_at >= 0) begin
            check({tag, ":no_done"}, 64'(done_cnt), 64'd0);
        end else begin
            check({tag, ":latency"}, 64'(done_at), 64'd17);
            check({tag, ":done_cnt"}, 64'(done_cnt), 64'd1);
            check({tag, ":result_at_done"}, got, exp);
        end
        check({tag, ":result_held"}, bus.result, exp);
        res_model = exp;
    endtask

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 4))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'($urandom_range(0, 15));
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.is_macc   = 1'b0;
        bus.is_msub   = 1'b0;
        bus.opa       = '0;
        bus.opb       = '0;
        bus.hilo_in   = '0;
        bus.cancel    = 1'b0;
        res_model     = '0;

        #1 resetn = 1'b0;
        #20;
        check("reset:busy", 64'(bus.busy), 64'd0);
        check("reset:done", 64'(bus.done), 64'd0);
        check("reset:result", bus.result, 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        do_op("multu_3x5", 0, 0, 0, 32'd3, 32'd5, 64'd0, -1, 0);
        check("multu_3x5:value", res_model, 64'h0000_0000_0000_000F);
        do_op("mult_m1sq", 1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, -1, 0);
        do_op("multu_m1sq", 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, -1, 0);
        do_op("madd", 1, 1, 0, 32'd2, 32'd3, 64'd10, -1, 0);
        do_op("msub", 1, 1, 1, 32'd4, 32'd3, 64'd10, -1, 0);
        do_op("msubu", 0, 1, 1, 32'h8000_0000, 32'd2, 64'd0, -1, 0);

        do_op("cancel5", 0, 0, 0, 32'd123, 32'd456, 64'd0, 5, 0);
        do_op("after_cancel", 0, 0, 0, 32'd1000, 32'd1000, 64'd0, -1, 0);

        // start and cancel together in IDLE: request dropped
        @(negedge clk);
        bus.start  = 1'b1;
        bus.cancel = 1'b1;
        bus.opa    = 32'd77;
        bus.opb    = 32'd11;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        check("start_cancel:busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        check("start_cancel:busy2", 64'(bus.busy), 64'd0);
        check("start_cancel:result", bus.result, res_model);

        do_op("hold_start", 1, 0, 0, 32'hFFFF_FFF9, 32'd12345, 64'd0, -1, 1);

        // async reset mid-CALC
        @(negedge clk);
        bus.start     = 1'b1;
        bus.signed_op = 1'b1;
        bus.is_macc   = 1'b0;
        bus.is_msub   = 1'b0;
        bus.opa       = 32'd12345;
        bus.opb       = 32'd678;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("async_rst:busy", 64'(bus.busy), 64'd0);
        check("async_rst:done", 64'(bus.done), 64'd0);
        check("async_rst:result", bus.result, 64'd0);
        @(negedge clk);
        resetn    = 1'b1;
        res_model = '0;
        do_op("multu_7x9", 0, 0, 0, 32'd7, 32'd9, 64'd0, -1, 0);

        for (int i = 0; i < 30; i++) begin
            int ca;
            bit hd;
            ca = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 16)) : -1;
            hd = (ca < 0) && ($urandom_range(0, 5) == 0);
            do_op($sformatf("rnd%0d", i), 1'($urandom), 1'($urandom), 1'($urandom),
                  pick_op(), pick_op(), {$urandom, $urandom}, ca, hd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

endmodule
